// File: rtl/mem_seq_ctrl_pkg.sv
// Shared definitions for the memory sequencer: state encodings, the default
// bus timeout and small helpers used by the top level and the bus timer.
package mem_seq_ctrl_pkg;

    // Width of the sequencer state register.
    localparam int STATE_W = 3;

    // State encodings kept as plain constants so the encoding stays fixed
    // and visible on a debug bus or in a waveform without enum decoding.
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] ST_CHECK  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACCESS = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERR    = 3'd5;

    // Maximum cycles a bus transfer may wait for an acknowledge; 0 disables.
    localparam int DEFAULT_TIMEOUT = 16;

    // Wait counter width: enough to hold TIMEOUT, never narrower than 1 bit
    // so a disabled timer still elaborates to a legal vector.
    function automatic int timerWidth(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

    // True for the two states that own an outstanding bus transfer.
    function automatic logic isXferState(input logic [STATE_W-1:0] state);
        return (state == ST_FETCH) || (state == ST_ACCESS);
    endfunction

endpackage

// File: rtl/mem_seq_ctrl_bus_timer.sv
// Wait-cycle counter for one bus transfer. It is cleared while no transfer
// is outstanding, counts every cycle the bus leaves a transfer unacknowledged,
// and flags expiry once the count reaches TIMEOUT-1 so the sequencer can
// abandon the transfer on that same edge.
module bus_timer
    import mem_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = timerWidth(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;
    logic          w_atLimit;

    assign w_atLimit = (r_count == LIMIT);
    assign o_expired = (TIMEOUT != 0) && w_atLimit;

    // Count unacknowledged cycles, saturating at the limit so the counter
    // cannot wrap back to zero while the sequencer is leaving the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_atLimit) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Sequencer that lets a single-cycle datapath share one single-port,
// variable-latency memory bus. Each instruction is fetched, decoded for one
// cycle, optionally followed by one data access, and the datapath is held
// stalled until a single commit cycle. A transfer that is never acknowledged
// parks the sequencer in a sticky error state until reset.
module mem_seq_ctrl
    import mem_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        cpu_stall,
    output logic        bus_cs,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack,
    output logic        err
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_nextState;

    logic               r_busCs;
    logic               r_busWe;
    logic [31:0]        r_busAddr;
    logic [31:0]        r_busDout;
    logic [31:0]        r_instData;
    logic [31:0]        r_memDin;
    logic               r_err;

    logic               w_inXfer;
    logic               w_memReq;
    logic               w_expired;

    assign w_inXfer = isXferState(r_state);
    assign w_memReq = mem_ren | mem_wen;

    // The timer only runs while a transfer is outstanding; outside FETCH and
    // ACCESS it is held clear so every new transfer starts counting from zero.
    bus_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_busTimer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_inXfer),
        .i_enable  (w_inXfer && !bus_ack),
        .o_expired (w_expired)
    );

    // Next-state decode; an acknowledge wins over a timeout in the same cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_en && inst_ren) begin
                    w_nextState = ST_FETCH;
                end else if (cpu_en && w_memReq) begin
                    w_nextState = ST_ACCESS;
                end
            end
            ST_FETCH: begin
                if (bus_ack) begin
                    w_nextState = ST_CHECK;
                end else if (w_expired) begin
                    w_nextState = ST_ERR;
                end
            end
            ST_CHECK: begin
                w_nextState = w_memReq ? ST_ACCESS : ST_DONE;
            end
            ST_ACCESS: begin
                if (bus_ack) begin
                    w_nextState = ST_DONE;
                end else if (w_expired) begin
                    w_nextState = ST_ERR;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            ST_ERR: begin
                w_nextState = ST_ERR;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Bus registers load on entry to a transfer and stay frozen until the
    // transfer ends, so datapath inputs moving mid-transfer never reach the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busCs   <= 1'b0;
            r_busWe   <= 1'b0;
            r_busAddr <= '0;
            r_busDout <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_CHECK: begin
                    if (w_nextState == ST_FETCH) begin
                        r_busCs   <= 1'b1;
                        r_busWe   <= 1'b0;
                        r_busAddr <= inst_addr;
                    end else if (w_nextState == ST_ACCESS) begin
                        r_busCs   <= 1'b1;
                        r_busWe   <= mem_wen;
                        r_busAddr <= mem_addr;
                        r_busDout <= mem_dout;
                    end
                end
                ST_FETCH, ST_ACCESS: begin
                    if (bus_ack || w_expired) begin
                        r_busCs   <= 1'b0;
                        r_busWe   <= 1'b0;
                        r_busAddr <= '0;
                        r_busDout <= '0;
                    end
                end
                ST_ERR: begin
                    r_busCs   <= 1'b0;
                    r_busWe   <= 1'b0;
                    r_busAddr <= '0;
                    r_busDout <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Capture fetched instructions and load data; a write access (including
    // the read+write case, where the write wins) leaves load data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instData <= '0;
            r_memDin   <= '0;
        end else begin
            if (r_state == ST_FETCH && bus_ack) begin
                r_instData <= bus_din;
            end
            if (r_state == ST_ACCESS && bus_ack && !r_busWe) begin
                r_memDin <= bus_din;
            end
        end
    end

    // Sticky error flag, raised together with entry into the error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_nextState == ST_ERR) begin
            r_err <= 1'b1;
        end
    end

    assign cpu_stall = (r_state != ST_DONE);
    assign bus_cs    = r_busCs;
    assign bus_we    = r_busWe;
    assign bus_addr  = r_busAddr;
    assign bus_dout  = r_busDout;
    assign inst_data = r_instData;
    assign mem_din   = r_memDin;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl. Stimulus pushes expected bus transfers
// and expected commits into queues; separate monitors pop and compare them
// when the DUT starts a bus transfer or opens its commit cycle. A simple bus
// responder acknowledges transfers after a scripted number of wait cycles.
module tb_mem_seq_ctrl;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] dout;
    } busExp_t;

    typedef struct {
        int          waits;
        logic [31:0] data;
    } busResp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] din;
    } commitExp_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cpu_en    = 1'b0;
    logic        inst_ren  = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        mem_ren   = 1'b0;
    logic        mem_wen   = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [31:0] mem_dout  = '0;
    logic [31:0] bus_din   = '0;
    logic        bus_ack   = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] mem_din;
    logic        cpu_stall;
    logic        bus_cs;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_dout;
    logic        err;

    int         checks   = 0;
    int         failures = 0;
    int         respWaitCnt = 0;
    busExp_t    busQ[$];
    busResp_t   respQ[$];
    commitExp_t commitQ[$];
    busResp_t   respHead;
    busExp_t    busCur;
    logic       busCurValid = 1'b0;
    logic       prevCs = 1'b0;
    commitExp_t commitCur;

    mem_seq_ctrl #(
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .inst_ren  (inst_ren),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .cpu_stall (cpu_stall),
        .bus_cs    (bus_cs),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_dout  (bus_dout),
        .bus_din   (bus_din),
        .bus_ack   (bus_ack),
        .err       (err)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point shared by every process.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // All outputs at their reset values.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cpuStall"}, 32'(cpu_stall), 32'd1);
        checkOutput({tag, "_instData"}, inst_data, 32'h0);
        checkOutput({tag, "_memDin"}, mem_din, 32'h0);
        checkOutput({tag, "_busCs"}, 32'(bus_cs), 32'd0);
        checkOutput({tag, "_busWe"}, 32'(bus_we), 32'd0);
        checkOutput({tag, "_busAddr"}, bus_addr, 32'h0);
        checkOutput({tag, "_busDout"}, bus_dout, 32'h0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Present one instruction request; called on a falling edge (cycle 1).
    task automatic applyStimulus(input logic instRen, input logic [31:0] iAddr,
                                 input logic mRen, input logic mWen,
                                 input logic [31:0] mAddr, input logic [31:0] mDout);
        cpu_en    = 1'b1;
        inst_ren  = instRen;
        inst_addr = iAddr;
        mem_ren   = mRen;
        mem_wen   = mWen;
        mem_addr  = mAddr;
        mem_dout  = mDout;
    endtask

    task automatic idleInputs();
        cpu_en   = 1'b0;
        inst_ren = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
    endtask

    // Wait (bounded) for the commit cycle and check when it arrived and that
    // it lasts exactly one cycle.
    task automatic waitCommit(input string name, input int startCyc, input int expCyc);
        int  cyc;
        bit  seen;
        cyc  = startCyc;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (!cpu_stall) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: no commit within %0d cycles, expected commit in cycle %0d", name, cyc, expCyc);
            idleInputs();
        end else begin
            checkOutput(name, 32'(cyc), 32'(expCyc));
            idleInputs();
            @(negedge clk);
            checkOutput({name, "_stallAfter"}, 32'(cpu_stall), 32'd1);
        end
    endtask

    // Bus responder: acknowledges the active transfer after the scripted
    // number of wait cycles; with nothing scripted the transfer is left hanging.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst || !bus_cs || respQ.size() == 0) begin
                bus_ack     = 1'b0;
                respWaitCnt = 0;
            end else if (respWaitCnt == respQ[0].waits) begin
                respHead    = respQ.pop_front();
                bus_ack     = 1'b1;
                bus_din     = respHead.data;
                respWaitCnt = 0;
            end else begin
                bus_ack     = 1'b0;
                bus_din     = 32'hBAD0BAD0;
                respWaitCnt++;
            end
        end
    end

    // Bus monitor: checks each new transfer against the scoreboard and
    // checks that the bus stays frozen while the transfer is outstanding.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_cs && !prevCs) begin
                if (busQ.size() == 0) begin
                    checks++;
                    failures++;
                    busCurValid = 1'b0;
                    $display("[TB] FAIL busStart: unexpected transfer addr 0x%08h we %0d, expected none", bus_addr, bus_we);
                end else begin
                    busCur      = busQ.pop_front();
                    busCurValid = 1'b1;
                    checkOutput("busStartWe", 32'(bus_we), 32'(busCur.we));
                    checkOutput("busStartAddr", bus_addr, busCur.addr);
                    if (busCur.we) checkOutput("busStartDout", bus_dout, busCur.dout);
                end
            end else if (bus_cs && busCurValid) begin
                checkOutput("busHoldWe", 32'(bus_we), 32'(busCur.we));
                checkOutput("busHoldAddr", bus_addr, busCur.addr);
            end
            prevCs = bus_cs;
        end
    end

    // Commit monitor: compares the captured registers in every commit cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !cpu_stall) begin
                if (commitQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL commit: unexpected commit inst 0x%08h, expected none", inst_data);
                end else begin
                    commitCur = commitQ.pop_front();
                    checkOutput("commitInst", inst_data, commitCur.inst);
                    checkOutput("commitMemDin", mem_din, commitCur.din);
                end
            end
        end
    end

    // Hard stop if something hangs beyond all bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        repeat (2) @(negedge clk);
        checkResetValues("inReset");
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("afterRelease");

        // Non-memory instruction, zero-wait fetch: 4 cycles.
        respQ.push_back('{0, 32'h20080005});
        busQ.push_back('{1'b0, 32'h0, 32'h0});
        commitQ.push_back('{32'h20080005, 32'h0});
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        waitCommit("nonMemCycles", 1, 4);

        // Load with two bus wait cycles on the data access: DONE in cycle 7.
        respQ.push_back('{0, 32'h8C090004});
        respQ.push_back('{2, 32'hDEADBEEF});
        busQ.push_back('{1'b0, 32'h4, 32'h0});
        busQ.push_back('{1'b0, 32'h4, 32'h0});
        commitQ.push_back('{32'h8C090004, 32'hDEADBEEF});
        applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h4, 32'h0);
        waitCommit("loadCycles", 1, 7);

        // Store with read and write both requested: write wins, load data kept.
        respQ.push_back('{0, 32'hAC0A0008});
        respQ.push_back('{1, 32'hFFFFFFFF});
        busQ.push_back('{1'b0, 32'h8, 32'h0});
        busQ.push_back('{1'b1, 32'h8, 32'h12345678});
        commitQ.push_back('{32'hAC0A0008, 32'hDEADBEEF});
        applyStimulus(1'b1, 32'h8, 1'b1, 1'b1, 32'h8, 32'h12345678);
        waitCommit("storeCycles", 1, 6);

        // Data-only access reusing the held instruction: IDLE, ACCESS, DONE.
        respQ.push_back('{0, 32'hCAFEF00D});
        busQ.push_back('{1'b0, 32'h10, 32'h0});
        commitQ.push_back('{32'hAC0A0008, 32'hCAFEF00D});
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        waitCommit("dataOnlyCycles", 1, 3);

        // Fetch request held off by cpu_en=0 for 10 cycles.
        cpu_en    = 1'b0;
        inst_ren  = 1'b1;
        inst_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("gatedBusCs", 32'(bus_cs), 32'd0);
            checkOutput("gatedStall", 32'(cpu_stall), 32'd1);
        end
        respQ.push_back('{0, 32'h01095020});
        busQ.push_back('{1'b0, 32'h20, 32'h0});
        commitQ.push_back('{32'h01095020, 32'hCAFEF00D});
        cpu_en = 1'b1;
        @(negedge clk);
        checkOutput("enableFetchCs", 32'(bus_cs), 32'd1);
        waitCommit("gatedCycles", 2, 4);

        // Reset asserted between edges while a data access is outstanding.
        respQ.push_back('{0, 32'h8C100040});
        busQ.push_back('{1'b0, 32'h30, 32'h0});
        busQ.push_back('{1'b0, 32'h40, 32'h0});
        applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("midAccessCs", 32'(bus_cs), 32'd1);
        checkOutput("midAccessAddr", bus_addr, 32'h40);
        #1;
        rst = 1'b1;
        #1;
        checkResetValues("midReset");
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        @(negedge clk);

        // Fetch never acknowledged: ERR entered 4 cycles after FETCH entry.
        busQ.push_back('{1'b0, 32'h50, 32'h0});
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checkOutput("toWaitCs", 32'(bus_cs), 32'd1);
            checkOutput("toWaitErr", 32'(err), 32'd0);
        end
        @(negedge clk);
        checkOutput("toErr", 32'(err), 32'd1);
        checkOutput("toErrCs", 32'(bus_cs), 32'd0);
        checkOutput("toErrStall", 32'(cpu_stall), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("errHeld", 32'(err), 32'd1);
            checkOutput("errHeldStall", 32'(cpu_stall), 32'd1);
            checkOutput("errHeldCs", 32'(bus_cs), 32'd0);
        end
        idleInputs();
        rst = 1'b1;
        #1;
        checkResetValues("errReset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("afterErrReset");

        // Normal operation resumes after reset.
        respQ.push_back('{0, 32'h3C01ABCD});
        busQ.push_back('{1'b0, 32'h60, 32'h0});
        commitQ.push_back('{32'h3C01ABCD, 32'h0});
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0);
        waitCommit("recoverCycles", 1, 4);

        repeat (2) @(negedge clk);
        checkOutput("busQEmpty", 32'(busQ.size()), 32'd0);
        checkOutput("commitQEmpty", 32'(commitQ.size()), 32'd0);
        checkOutput("respQEmpty", 32'(respQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
